// File: rtl/ss_pkg.sv
// Shared types and constants for the world-map sequencer.
package ss_pkg;

  localparam int unsigned MAP_IDX_W = 4;

  typedef logic [MAP_IDX_W-1:0] map_idx_t;

  typedef enum logic [1:0] {
    ARM_WAIT = 2'd0,
    PLAY     = 2'd1,
    HOLD     = 2'd2
  } state_t;

  localparam logic [7:0] DEF_RIGHT_EDGE = 8'h7C;
  localparam logic [7:0] DEF_LEFT_EDGE  = 8'h01;

endpackage

// File: rtl/ss_map_mux.sv
// Registered NUM_MAPS-way selector of one PIX_W slice; out-of-range select picks the last map.
module ss_map_mux #(
  parameter int unsigned NUM_MAPS = 4,
  parameter int unsigned PIX_W    = 2,
  parameter int unsigned SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SEL_W-1:0]          i_sel,
  input  logic [NUM_MAPS*PIX_W-1:0] i_data,
  output logic [PIX_W-1:0]          o_pix
);

  logic [PIX_W-1:0] w_sel;
  logic [PIX_W-1:0] r_pix;

  always_comb begin
    w_sel = i_data[(NUM_MAPS-1)*PIX_W +: PIX_W];
    for (int k = 0; k < int'(NUM_MAPS) - 1; k++) begin
      if (i_sel == SEL_W'(k)) w_sel = i_data[k*PIX_W +: PIX_W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_pix <= '0;
    else        r_pix <= w_sel;
  end

  assign o_pix = r_pix;

endmodule

// File: rtl/ss_map_sequencer.sv
// Tracks the active world map from player X position, with edge hold-off and teleport pulses.
// Define SS_MAP_WRAP_EN to wrap between the last map and map 0.
module ss_map_sequencer
  import ss_pkg::*;
#(
  parameter int unsigned       NUM_MAPS   = 4,
  parameter int unsigned       LOCX_W     = 8,
  parameter int unsigned       PIX_W      = 2,
  parameter logic [LOCX_W-1:0] RIGHT_EDGE = LOCX_W'(DEF_RIGHT_EDGE),
  parameter logic [LOCX_W-1:0] LEFT_EDGE  = LOCX_W'(DEF_LEFT_EDGE),
  parameter int unsigned       HOLDOFF    = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [LOCX_W-1:0]           locx,
  input  logic [NUM_MAPS*PIX_W-1:0]   map_data_in,
  input  logic [NUM_MAPS*PIX_W-1:0]   map_pix_in,
  output logic [PIX_W-1:0]            worldmap_data,
  output logic [PIX_W-1:0]            world_pixel,
  output logic [$clog2(NUM_MAPS)-1:0] cur_map,
  output logic                        tp_left,
  output logic                        tp_right
);

  localparam int unsigned CUR_W = $clog2(NUM_MAPS);
  localparam int unsigned CNT_W = $clog2(HOLDOFF + 1);
  localparam logic [CUR_W-1:0] LAST_MAP  = CUR_W'(NUM_MAPS - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF - 1);

  state_t           r_state, w_state_nxt;
  logic [CUR_W-1:0] r_cur_map, w_map_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_tp_left, w_tp_left_nxt;
  logic             r_tp_right, w_tp_right_nxt;
  logic             w_at_right, w_at_left;

  // Right edge wins if both edges ever compare equal.
  assign w_at_right = (locx == RIGHT_EDGE);
  assign w_at_left  = (locx == LEFT_EDGE) && !w_at_right;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ARM_WAIT;
      r_cur_map  <= '0;
      r_cnt      <= '0;
      r_tp_left  <= 1'b0;
      r_tp_right <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur_map  <= w_map_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tp_left  <= w_tp_left_nxt;
      r_tp_right <= w_tp_right_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_map_nxt      = r_cur_map;
    w_cnt_nxt      = r_cnt;
    w_tp_left_nxt  = 1'b0;
    w_tp_right_nxt = 1'b0;
    unique case (r_state)
      ARM_WAIT: begin
        if (!w_at_right && !w_at_left) w_state_nxt = PLAY;
      end
      PLAY: begin
        if (w_at_right) begin
          if (r_cur_map < LAST_MAP) begin
            w_map_nxt     = r_cur_map + CUR_W'(1);
            w_tp_left_nxt = 1'b1;
            w_state_nxt   = HOLD;
            w_cnt_nxt     = HOLD_LOAD;
          end else begin
`ifdef SS_MAP_WRAP_EN
            w_map_nxt     = '0;
            w_tp_left_nxt = 1'b1;
            w_state_nxt   = HOLD;
            w_cnt_nxt     = HOLD_LOAD;
`endif
          end
        end else if (w_at_left) begin
          if (r_cur_map != '0) begin
            w_map_nxt      = r_cur_map - CUR_W'(1);
            w_tp_right_nxt = 1'b1;
            w_state_nxt    = HOLD;
            w_cnt_nxt      = HOLD_LOAD;
          end else begin
`ifdef SS_MAP_WRAP_EN
            w_map_nxt      = LAST_MAP;
            w_tp_right_nxt = 1'b1;
            w_state_nxt    = HOLD;
            w_cnt_nxt      = HOLD_LOAD;
`endif
          end
        end
      end
      HOLD: begin
        if (r_cnt != '0)                    w_cnt_nxt   = r_cnt - CNT_W'(1);
        else if (!w_at_right && !w_at_left) w_state_nxt = PLAY;
      end
      default: w_state_nxt = ARM_WAIT;
    endcase
  end

  assign cur_map  = r_cur_map;
  assign tp_left  = r_tp_left;
  assign tp_right = r_tp_right;

  ss_map_mux #(.NUM_MAPS(NUM_MAPS), .PIX_W(PIX_W), .SEL_W(CUR_W)) u_mux_a (
    .clk    (clk),
    .reset  (reset),
    .i_sel  (r_cur_map),
    .i_data (map_data_in),
    .o_pix  (worldmap_data)
  );

  ss_map_mux #(.NUM_MAPS(NUM_MAPS), .PIX_W(PIX_W), .SEL_W(CUR_W)) u_mux_b (
    .clk    (clk),
    .reset  (reset),
    .i_sel  (r_cur_map),
    .i_data (map_pix_in),
    .o_pix  (world_pixel)
  );

endmodule
